// File: rtl/rv_pkg.sv
// ============================================================================
// Package     : rv_pkg
// Description : Shared RV32 definitions. Holds the datapath widths, ALU
//               encodings, operand selects and the ID/EX registered bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int RV_WIDTH  = 32;
    localparam int RV_REG_AW = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic A_SEL_RS1 = 1'b0;
    localparam logic A_SEL_PC  = 1'b1;
    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    typedef struct packed {
        logic [RV_WIDTH-1:0]  pc;
        logic [RV_WIDTH-1:0]  rs1_data;
        logic [RV_WIDTH-1:0]  rs2_data;
        logic [RV_WIDTH-1:0]  imm;
        logic [RV_REG_AW-1:0] rs1_addr;
        logic [RV_REG_AW-1:0] rs2_addr;
        logic [RV_REG_AW-1:0] rd_addr;
        logic [3:0]           alu_sel;
        logic                 a_sel;
        logic                 b_sel;
        logic                 rd_we;
        logic                 is_load;
    } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ============================================================================
// Module      : fwd_mux
// Description : Source-priority operand forwarding mux (MEM over WB over the
//               registered value); register x0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_mux #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic              mem_rd_we,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]  mem_rd_data,
    input  logic              wb_rd_we,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [WIDTH-1:0]  wb_rd_data,
    output logic [WIDTH-1:0]  fwd_data
);

    logic w_rs_nonzero;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_rs_nonzero = (rs_addr != '0);
    assign w_mem_hit    = w_rs_nonzero & mem_rd_we & (mem_rd_addr == rs_addr);
    assign w_wb_hit     = w_rs_nonzero & wb_rd_we & (wb_rd_addr == rs_addr);

    always_comb begin
        fwd_data = rs_data;
        if (w_mem_hit) begin
            fwd_data = mem_rd_data;
        end else if (w_wb_hit) begin
            fwd_data = wb_rd_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : RV32 ID/EX pipeline register with MEM/WB forwarding, ALU
//               operand selection and load-use bubble insertion.
//               Optional event counters enabled by macro ID_EX_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import rv_pkg::*;
#(
    parameter int WIDTH  = RV_WIDTH,
    parameter int REG_AW = RV_REG_AW
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    output logic              id_ready,
    input  logic [WIDTH-1:0]  id_pc,
    input  logic [WIDTH-1:0]  id_rs1_data,
    input  logic [WIDTH-1:0]  id_rs2_data,
    input  logic [WIDTH-1:0]  id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [3:0]        id_alu_sel,
    input  logic              id_a_sel,
    input  logic              id_b_sel,
    input  logic              id_rd_we,
    input  logic              id_is_load,

    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [WIDTH-1:0]  ex_alu_a,
    output logic [WIDTH-1:0]  ex_alu_b,
    output logic [3:0]        ex_alu_sel,
    output logic [WIDTH-1:0]  ex_pc,
    output logic [WIDTH-1:0]  ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_rd_we,
    output logic              ex_is_load,

    input  logic              mem_rd_we,
    input  logic              wb_rd_we,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [WIDTH-1:0]  mem_rd_data,
    input  logic [WIDTH-1:0]  wb_rd_data,

    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
);

    id_ex_t             r_ex;
    logic               r_ex_valid;
    id_ex_t             w_id;
    logic               w_advance;
    logic               w_hazard;
    logic               w_capture;
    logic               w_wb_refresh;
    logic [WIDTH-1:0]   w_fwd_rs1;
    logic [WIDTH-1:0]   w_fwd_rs2;

    assign w_advance = ~r_ex_valid | ex_ready;
    assign w_hazard  = r_ex_valid & r_ex.is_load & (r_ex.rd_addr != '0) &
                       ((id_rs1_used & (id_rs1_addr == r_ex.rd_addr)) |
                        (id_rs2_used & (id_rs2_addr == r_ex.rd_addr)));
    assign w_capture = w_advance & id_valid & ~w_hazard;
    assign id_ready  = w_advance & ~w_hazard;

    // A stalled instruction must not miss a value retiring from WB while it waits.
    assign w_wb_refresh = wb_rd_we & (wb_rd_addr != '0);

    always_comb begin
        w_id          = '0;
        w_id.pc       = id_pc;
        w_id.rs1_data = id_rs1_data;
        w_id.rs2_data = id_rs2_data;
        w_id.imm      = id_imm;
        w_id.rs1_addr = id_rs1_addr;
        w_id.rs2_addr = id_rs2_addr;
        w_id.rd_addr  = id_rd_addr;
        w_id.alu_sel  = id_alu_sel;
        w_id.a_sel    = id_a_sel;
        w_id.b_sel    = id_b_sel;
        w_id.rd_we    = id_rd_we;
        w_id.is_load  = id_is_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_advance) begin
            r_ex_valid <= w_capture;
            if (w_capture) begin
                r_ex <= w_id;
            end
        end else if (r_ex_valid) begin
            if (w_wb_refresh && (wb_rd_addr == r_ex.rs1_addr)) begin
                r_ex.rs1_data <= wb_rd_data;
            end
            if (w_wb_refresh && (wb_rd_addr == r_ex.rs2_addr)) begin
                r_ex.rs2_data <= wb_rd_data;
            end
        end
    end

    fwd_mux #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW)
    ) u_fwd_rs1 (
        .rs_addr     (r_ex.rs1_addr),
        .rs_data     (r_ex.rs1_data),
        .mem_rd_we   (mem_rd_we),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .wb_rd_we    (wb_rd_we),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_data  (wb_rd_data),
        .fwd_data    (w_fwd_rs1)
    );

    fwd_mux #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW)
    ) u_fwd_rs2 (
        .rs_addr     (r_ex.rs2_addr),
        .rs_data     (r_ex.rs2_data),
        .mem_rd_we   (mem_rd_we),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .wb_rd_we    (wb_rd_we),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_data  (wb_rd_data),
        .fwd_data    (w_fwd_rs2)
    );

    assign ex_valid      = r_ex_valid;
    assign ex_alu_a      = (r_ex.a_sel == A_SEL_PC)  ? r_ex.pc  : w_fwd_rs1;
    assign ex_alu_b      = (r_ex.b_sel == B_SEL_IMM) ? r_ex.imm : w_fwd_rs2;
    assign ex_alu_sel    = r_ex.alu_sel;
    assign ex_pc         = r_ex.pc;
    assign ex_store_data = w_fwd_rs2;
    assign ex_rd_addr    = r_ex.rd_addr;
    assign ex_rd_we      = r_ex.rd_we;
    assign ex_is_load    = r_ex.is_load;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_hazard & id_valid & w_advance) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_advance & ~flush & ~(id_valid & ~w_hazard)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (flush & r_ex_valid) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`else
    assign perf_stall_cnt  = '0;
    assign perf_bubble_cnt = '0;
    assign perf_flush_cnt  = '0;
`endif

endmodule

`default_nettype wire
